// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM fetchers (tank, bullet, explosion).
package sprite_pkg;

  localparam int SPR_DIM  = 32;
  localparam int SCREEN_W = 640;
  localparam logic [23:0] KEY_COLOR = 24'hFF0000;

  localparam int IDX_W  = $clog2(SPR_DIM);
  localparam int ADDR_W = 2 * IDX_W;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SPR_DIM - 1);

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_RIGHT,
    DIR_DOWN,
    DIR_LEFT
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_t;

endpackage

// File: rtl/sprite_rot_addr.sv
// Maps a displayed (row, col) to the ROM address of the source pixel for one of
// four sprite orientations; purely combinational.
module sprite_rot_addr
  import sprite_pkg::*;
(
  input  logic [IDX_W-1:0]  row_i,
  input  logic [IDX_W-1:0]  col_i,
  input  dir_t              dir_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [IDX_W-1:0] src_r;
  logic [IDX_W-1:0] src_c;

  always_comb begin
    src_r = row_i;
    src_c = col_i;
    unique case (dir_i)
      DIR_UP: begin
        src_r = row_i;
        src_c = col_i;
      end
      DIR_RIGHT: begin
        src_r = IDX_MAX - col_i;
        src_c = row_i;
      end
      DIR_DOWN: begin
        src_r = IDX_MAX - row_i;
        src_c = IDX_MAX - col_i;
      end
      DIR_LEFT: begin
        src_r = col_i;
        src_c = IDX_MAX - row_i;
      end
      default: begin
        src_r = row_i;
        src_c = col_i;
      end
    endcase
  end

  // SPR_DIM is a power of two, so r*SPR_DIM + c is a plain concatenation.
  assign addr_o = {src_r, src_c};

endmodule

// File: rtl/sprite_line_fetch.sv
// Per-scanline sprite row fetcher: reads one rotated sprite row from ROM during
// horizontal blank and writes its opaque, on-screen pixels into the line buffer.
module sprite_line_fetch
  import sprite_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [9:0]  line_y,
  input  logic [9:0]  spr_x,
  input  logic [9:0]  spr_y,
  input  logic [1:0]  dir,
  output logic        busy,
  output logic        done,
  output logic [18:0] read_address,
  input  logic [23:0] rom_data,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [23:0] pix_data
);

  fetch_state_t     state_q, state_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [9:0]       line_y_q, spr_x_q, spr_y_q;
  dir_t             dir_q;

  logic             vld_p1_q;
  logic [IDX_W-1:0] col_p1_q;
  logic [9:0]       pix_x_q;
  logic [23:0]      pix_data_q;

  logic [9:0]        row_full;
  logic              hit;
  logic [ADDR_W-1:0] rot_addr;
  logic [10:0]       x_sum;

  assign row_full = line_y_q - spr_y_q;
  assign hit      = (line_y_q >= spr_y_q) && (row_full < 10'(SPR_DIM));

  sprite_rot_addr u_rot (
    .row_i  (row_full[IDX_W-1:0]),
    .col_i  (col_q),
    .dir_i  (dir_q),
    .addr_o (rot_addr)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (hit) begin
          state_d = ST_FETCH;
          col_d   = '0;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FETCH: begin
        col_d = col_q + IDX_W'(1);
        if (col_q == IDX_MAX) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign read_address = (state_q == ST_FETCH) ? {{(19-ADDR_W){1'b0}}, rot_addr} : 19'd0;

  // p1: ROM data for the column issued last cycle is on rom_data now.
  assign x_sum    = {1'b0, spr_x_q} + {{(11-IDX_W){1'b0}}, col_p1_q};
  assign pix_we   = vld_p1_q && (rom_data != KEY_COLOR) && (x_sum < 11'(SCREEN_W));
  assign pix_x    = pix_we ? x_sum[9:0] : pix_x_q;
  assign pix_data = pix_we ? rom_data : pix_data_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      vld_p1_q   <= 1'b0;
      pix_x_q    <= '0;
      pix_data_q <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      vld_p1_q <= (state_q == ST_FETCH);
      if (pix_we) begin
        pix_x_q    <= x_sum[9:0];
        pix_data_q <= rom_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    col_p1_q <= col_q;
    if (state_q == ST_IDLE && start) begin
      line_y_q <= line_y;
      spr_x_q  <= spr_x;
      spr_y_q  <= spr_y;
      dir_q    <= dir_t'(dir);
    end
  end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Directed bench for sprite_line_fetch with a one-cycle-latency ROM model.
module tb_sprite_line_fetch;

  localparam int KEY = 24'hFF0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  line_y = '0;
  logic [9:0]  spr_x = '0;
  logic [9:0]  spr_y = '0;
  logic [1:0]  dir = '0;
  logic        busy, done, pix_we;
  logic [18:0] read_address;
  logic [23:0] rom_data = '0;
  logic [9:0]  pix_x;
  logic [23:0] pix_data;

  int total = 0;
  int bad = 0;

  logic [18:0] addr_log [0:63];
  logic        we_log   [0:63];
  logic [9:0]  x_log    [0:63];
  logic [23:0] data_log [0:63];
  logic        done_log [0:63];
  logic        busy_log [0:63];

  sprite_line_fetch dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .line_y       (line_y),
    .spr_x        (spr_x),
    .spr_y        (spr_y),
    .dir          (dir),
    .busy         (busy),
    .done         (done),
    .read_address (read_address),
    .rom_data     (rom_data),
    .pix_we       (pix_we),
    .pix_x        (pix_x),
    .pix_data     (pix_data)
  );

  always #5 Clk = ~Clk;

  // ROM model: {14'h0, a} one cycle after address a, KEY_COLOR at address 5.
  always @(posedge Clk) begin
    if (read_address == 19'd5) rom_data <= 24'(KEY);
    else                       rom_data <= {14'h0, read_address[9:0]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int rot_model(input int row, input int col, input int d);
    int r, c;
    case (d)
      0:       begin r = row;      c = col;      end
      1:       begin r = 31 - col; c = row;      end
      2:       begin r = 31 - row; c = 31 - col; end
      default: begin r = col;      c = 31 - row; end
    endcase
    return r * 32 + c;
  endfunction

  // Drives a start pulse in cycle 0 and logs cycles 1..ncyc at the falling edge.
  task automatic run(input int ly, input int sx, input int sy, input int d,
                     input int ncyc, input int restart_at, input int reset_at);
    @(negedge Clk);
    line_y = 10'(ly); spr_x = 10'(sx); spr_y = 10'(sy); dir = 2'(d);
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge Clk);
      addr_log[k] = read_address;
      we_log[k]   = pix_we;
      x_log[k]    = pix_x;
      data_log[k] = pix_data;
      done_log[k] = done;
      busy_log[k] = busy;
      start = 1'b0;
      if (k == restart_at) begin
        start  = 1'b1;
        line_y = 10'(ly + 40);
        spr_x  = 10'(sx + 3);
        dir    = 2'(d + 1);
      end
      if (k == reset_at) Reset = 1'b1;
      else               Reset = 1'b0;
    end
  endtask

  task automatic expect_run(input string tag, input int sx, input int sy, input int ly,
                            input int d, input int ncyc);
    int  row, col, a, ea, ed;
    bit  hit, ewe;
    row = ly - sy;
    hit = (ly >= sy) && (row < 32);
    for (int k = 1; k <= ncyc; k++) begin
      ea = 0;
      if (hit && k >= 2 && k <= 33) ea = rot_model(row, k - 2, d);
      check($sformatf("%s addr k%0d", tag, k), 32'(addr_log[k]), ea);
      ewe = 1'b0;
      ed  = 0;
      col = k - 3;
      if (hit && k >= 3 && k <= 34) begin
        a   = rot_model(row, col, d);
        ed  = (a == 5) ? KEY : a;
        ewe = (ed != KEY) && (sx + col < 640);
      end
      check($sformatf("%s we k%0d", tag, k), 32'(we_log[k]), 32'(ewe));
      if (ewe) begin
        check($sformatf("%s x k%0d", tag, k), 32'(x_log[k]), sx + col);
        check($sformatf("%s data k%0d", tag, k), 32'(data_log[k]), ed);
      end
      check($sformatf("%s done k%0d", tag, k), 32'(done_log[k]),
            hit ? 32'(k == 35) : 32'(k == 2));
      check($sformatf("%s busy k%0d", tag, k), 32'(busy_log[k]),
            hit ? 32'(k <= 35) : 32'(k <= 2));
    end
  endtask

  function automatic int count_we(input int ncyc);
    int n = 0;
    for (int k = 1; k <= ncyc; k++) if (we_log[k]) n++;
    return n;
  endfunction

  function automatic int data_at_x(input int x, input int ncyc);
    int v = -1;
    for (int k = 1; k <= ncyc; k++) if (we_log[k] && x_log[k] == 10'(x)) v = int'(data_log[k]);
    return v;
  endfunction

  function automatic int max_x(input int ncyc);
    int m = -1;
    for (int k = 1; k <= ncyc; k++) if (we_log[k] && int'(x_log[k]) > m) m = int'(x_log[k]);
    return m;
  endfunction

  initial begin
    int nd;
    repeat (3) @(negedge Clk);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst we", 32'(pix_we), 0);
    check("rst x", 32'(pix_x), 0);
    check("rst data", 32'(pix_data), 0);
    check("rst addr", 32'(read_address), 0);
    Reset = 1'b0;

    // Scenario 1: plain hit, dir up.
    run(50, 100, 50, 0, 37, -1, -1);
    expect_run("s1", 100, 50, 50, 0, 37);
    check("s1 nwrites", count_we(37), 31);
    check("s1 x105", data_at_x(105, 37), -1);
    check("s1 x101", data_at_x(101, 37), 1);
    check("s1 addr c2", 32'(addr_log[2]), 0);
    check("s1 addr c33", 32'(addr_log[33]), 31);

    // Scenario 2: dir down, last sprite row.
    run(131, 200, 100, 2, 37, -1, -1);
    expect_run("s2", 200, 100, 131, 2, 37);
    check("s2 x200", data_at_x(200, 37), 32'h1F);
    check("s2 addr c2", 32'(addr_log[2]), 31);
    check("s2 addr c33", 32'(addr_log[33]), 0);

    // Scenario 3: miss above and just below the sprite.
    run(99, 300, 100, 0, 6, -1, -1);
    expect_run("s3a", 300, 100, 99, 0, 6);
    check("s3a nwrites", count_we(6), 0);
    run(132, 300, 100, 3, 6, -1, -1);
    expect_run("s3b", 300, 100, 132, 3, 6);
    check("s3b nwrites", count_we(6), 0);

    // Scenario 4: dir right straddling the right edge, row 3.
    run(13, 620, 10, 1, 37, -1, -1);
    expect_run("s4", 620, 10, 13, 1, 37);
    check("s4 nwrites", count_we(37), 20);
    check("s4 maxx", max_x(37), 639);
    check("s4 addr c2", 32'(addr_log[2]), 31 * 32 + 3);

    // Scenario 5: second start at cycle 10 is ignored.
    run(60, 40, 40, 3, 40, 10, -1);
    expect_run("s5", 40, 40, 60, 3, 40);
    nd = 0;
    for (int k = 1; k <= 40; k++) if (done_log[k]) nd++;
    check("s5 ndone", nd, 1);

    // Scenario 6: reset at cycle 15, restart at cycle 17 completes at cycle 52.
    run(70, 400, 60, 0, 16, -1, 15);
    check("s6 busy15", 32'(busy_log[15]), 1);
    check("s6 busy16", 32'(busy_log[16]), 0);
    check("s6 we16", 32'(we_log[16]), 0);
    check("s6 addr16", 32'(addr_log[16]), 0);
    check("s6 done16", 32'(done_log[16]), 0);
    check("s6 x16", 32'(x_log[16]), 0);
    check("s6 data16", 32'(data_log[16]), 0);
    run(70, 400, 60, 0, 37, -1, -1);
    expect_run("s6r", 400, 60, 70, 0, 37);
    check("s6r nwrites", count_we(37), 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
